// File: rtl/alu_op_issue.sv
// alu_op_issue: decodes a MIPS instruction into ALU control and operands and holds
// them in a one-entry decode->EX register with valid/ready handshake, stall and flush.
module alu_op_issue #(
    parameter logic [4:0] LINK_REG     = 5'd31,
    parameter bit         TRAP_ILLEGAL = 1'b1
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        flush,
    input  logic        id_valid,
    output logic        id_ready,
    input  logic [31:0] id_instr,
    input  logic [31:0] id_pc_plus4,
    input  logic [31:0] id_rs_data,
    input  logic [31:0] id_rt_data,
    output logic        ex_valid,
    input  logic        ex_ready,
    output logic [5:0]  ex_alu_func,
    output logic        ex_signed,
    output logic [31:0] ex_alu_a,
    output logic [31:0] ex_alu_b,
    output logic [31:0] ex_store_data,
    output logic [4:0]  ex_dst_reg,
    output logic        ex_reg_write,
    output logic        ex_mem_read,
    output logic        ex_mem_write,
    output logic        ex_branch,
    output logic        ex_illegal
);
    localparam logic [5:0] F_ADD = 6'h00, F_SUB = 6'h01, F_AND = 6'h18, F_OR = 6'h1e,
                           F_XOR = 6'h16, F_NOR = 6'h11, F_PASS = 6'h1a, F_SLL = 6'h20,
                           F_SRL = 6'h21, F_SRA = 6'h23, F_EQ = 6'h33, F_NEQ = 6'h31,
                           F_LT = 6'h35, F_LEZ = 6'h3d, F_LTZ = 6'h3b, F_GTZ = 6'h3f;

    logic [5:0]  op, fn, d_func;
    logic [4:0]  rt, rd, d_dst;
    logic [31:0] simm, zimm, d_a, d_b, d_sd;
    logic        d_sgn, d_rw, d_mr, d_mw, d_br, d_ill, xfer;

    assign op       = id_instr[31:26];
    assign rt       = id_instr[20:16];
    assign rd       = id_instr[15:11];
    assign fn       = id_instr[5:0];
    assign simm     = {{16{id_instr[15]}}, id_instr[15:0]};
    assign zimm     = {16'b0, id_instr[15:0]};
    assign id_ready = ~ex_valid | ex_ready;
    assign xfer     = id_valid & id_ready;

    always_comb begin
        d_func = F_ADD;
        d_sgn  = 1'b0;
        d_a    = id_rs_data;
        d_b    = id_rt_data;
        d_sd   = 32'b0;
        d_dst  = 5'd0;
        d_rw   = 1'b0;
        d_mr   = 1'b0;
        d_mw   = 1'b0;
        d_br   = 1'b0;
        d_ill  = 1'b0;
        case (op)
            6'h00: begin
                d_dst = rd;
                d_rw  = 1'b1;
                case (fn)
                    6'h20, 6'h21: begin d_func = F_ADD; d_sgn = ~fn[0]; end
                    6'h22, 6'h23: begin d_func = F_SUB; d_sgn = ~fn[0]; end
                    6'h2a, 6'h2b: begin d_func = F_LT;  d_sgn = ~fn[0]; end
                    6'h24: d_func = F_AND;
                    6'h25: d_func = F_OR;
                    6'h26: d_func = F_XOR;
                    6'h27: d_func = F_NOR;
                    6'h00: begin d_func = F_SLL; d_a = {27'b0, id_instr[10:6]}; end
                    6'h02: begin d_func = F_SRL; d_a = {27'b0, id_instr[10:6]}; end
                    6'h03: begin d_func = F_SRA; d_a = {27'b0, id_instr[10:6]}; end
                    6'h04: d_func = F_SLL;
                    6'h06: d_func = F_SRL;
                    6'h07: d_func = F_SRA;
                    6'h08: begin d_rw = 1'b0; d_dst = 5'd0; d_br = 1'b1; end
                    6'h09: begin d_func = F_PASS; d_a = id_pc_plus4; d_b = 32'b0; d_br = 1'b1; end
                    default: d_ill = 1'b1;
                endcase
            end
            6'h08, 6'h09: begin d_func = F_ADD; d_sgn = ~op[0]; d_b = simm; d_dst = rt; d_rw = 1'b1; end
            6'h0a, 6'h0b: begin d_func = F_LT;  d_sgn = ~op[0]; d_b = simm; d_dst = rt; d_rw = 1'b1; end
            6'h0c: begin d_func = F_AND; d_b = zimm; d_dst = rt; d_rw = 1'b1; end
            6'h0d: begin d_func = F_OR;  d_b = zimm; d_dst = rt; d_rw = 1'b1; end
            6'h0e: begin d_func = F_XOR; d_b = zimm; d_dst = rt; d_rw = 1'b1; end
            6'h0f: begin d_func = F_SLL; d_a = 32'd16; d_b = zimm; d_dst = rt; d_rw = 1'b1; end
            6'h23: begin d_b = simm; d_dst = rt; d_rw = 1'b1; d_mr = 1'b1; end
            6'h2b: begin d_b = simm; d_sd = id_rt_data; d_mw = 1'b1; end
            6'h04: begin d_func = F_EQ;  d_sgn = 1'b1; d_br = 1'b1; end
            6'h05: begin d_func = F_NEQ; d_sgn = 1'b1; d_br = 1'b1; end
            6'h06: begin d_func = F_LEZ; d_sgn = 1'b1; d_b = 32'b0; d_br = 1'b1; end
            6'h07: begin d_func = F_GTZ; d_sgn = 1'b1; d_b = 32'b0; d_br = 1'b1; end
            6'h01: begin
                d_ill  = rt != 5'd0;
                d_func = F_LTZ;
                d_sgn  = 1'b1;
                d_b    = 32'b0;
                d_br   = 1'b1;
            end
            6'h02: d_br = 1'b1;
            6'h03: begin d_func = F_PASS; d_a = id_pc_plus4; d_b = 32'b0; d_dst = LINK_REG; d_rw = 1'b1; d_br = 1'b1; end
            default: d_ill = 1'b1;
        endcase
        // Undecodable instructions collapse to a NOP regardless of partial decode above
        if (d_ill) begin
            d_func = F_ADD;
            d_sgn  = 1'b0;
            d_dst  = 5'd0;
            d_rw   = 1'b0;
            d_mr   = 1'b0;
            d_mw   = 1'b0;
            d_br   = 1'b0;
            d_sd   = 32'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            ex_valid      <= 1'b0;
            ex_alu_func   <= F_ADD;
            ex_signed     <= 1'b0;
            ex_alu_a      <= 32'b0;
            ex_alu_b      <= 32'b0;
            ex_store_data <= 32'b0;
            ex_dst_reg    <= 5'd0;
            ex_reg_write  <= 1'b0;
            ex_mem_read   <= 1'b0;
            ex_mem_write  <= 1'b0;
            ex_branch     <= 1'b0;
            ex_illegal    <= 1'b0;
        end else if (flush) begin
            ex_valid <= 1'b0;
        end else if (xfer) begin
            ex_valid      <= 1'b1;
            ex_alu_func   <= d_func;
            ex_signed     <= d_sgn;
            ex_alu_a      <= d_a;
            ex_alu_b      <= d_b;
            ex_store_data <= d_sd;
            ex_dst_reg    <= d_dst;
            ex_reg_write  <= d_rw & (d_dst != 5'd0);
            ex_mem_read   <= d_mr;
            ex_mem_write  <= d_mw;
            ex_branch     <= d_br;
            ex_illegal    <= d_ill & TRAP_ILLEGAL;
        end else if (ex_ready) begin
            ex_valid <= 1'b0;
        end
    end
endmodule

// File: tb/tb_alu_op_issue.sv
// tb_alu_op_issue: table-driven decode checks plus reset, stall and flush sequences.
module tb_alu_op_issue;
    logic        clk = 1'b0, reset, flush, id_valid, id_ready, ex_ready, ex_valid;
    logic [31:0] id_instr, id_pc_plus4, id_rs_data, id_rt_data;
    logic [5:0]  ex_alu_func;
    logic        ex_signed, ex_reg_write, ex_mem_read, ex_mem_write, ex_branch, ex_illegal;
    logic [31:0] ex_alu_a, ex_alu_b, ex_store_data;
    logic [4:0]  ex_dst_reg;
    int tests = 0, fails = 0;

    always #5 clk = ~clk;

    alu_op_issue dut (
        .clk(clk), .reset(reset), .flush(flush), .id_valid(id_valid), .id_ready(id_ready),
        .id_instr(id_instr), .id_pc_plus4(id_pc_plus4), .id_rs_data(id_rs_data),
        .id_rt_data(id_rt_data), .ex_valid(ex_valid), .ex_ready(ex_ready),
        .ex_alu_func(ex_alu_func), .ex_signed(ex_signed), .ex_alu_a(ex_alu_a),
        .ex_alu_b(ex_alu_b), .ex_store_data(ex_store_data), .ex_dst_reg(ex_dst_reg),
        .ex_reg_write(ex_reg_write), .ex_mem_read(ex_mem_read), .ex_mem_write(ex_mem_write),
        .ex_branch(ex_branch), .ex_illegal(ex_illegal)
    );

    typedef struct {
        logic [31:0] instr, pc4, rs, rt;
        logic [5:0]  func;
        logic        sgn;
        logic [31:0] a, b, sd;
        logic [4:0]  dst;
        logic        rw, mr, mw, br, ill;
    } vec_t;

    vec_t v[$];

    function automatic logic [31:0] r_(input logic [4:0] rs, rt, rd, sh, input logic [5:0] fn);
        return {6'h00, rs, rt, rd, sh, fn};
    endfunction

    function automatic logic [31:0] i_(input logic [5:0] op, input logic [4:0] rs, rt, input logic [15:0] imm);
        return {op, rs, rt, imm};
    endfunction

    function automatic vec_t mk(input logic [31:0] instr, pc4, rs, rt, input logic [5:0] func,
                                input logic sgn, input logic [31:0] a, b, sd, input logic [4:0] dst,
                                input logic rw, mr, mw, br, ill);
        vec_t t;
        t.instr = instr; t.pc4 = pc4; t.rs = rs; t.rt = rt; t.func = func; t.sgn = sgn;
        t.a = a; t.b = b; t.sd = sd; t.dst = dst; t.rw = rw; t.mr = mr; t.mw = mw;
        t.br = br; t.ill = ill;
        return t;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        reset = 1'b1; flush = 1'b0; id_valid = 1'b1; ex_ready = 1'b1;
        id_instr = i_(6'h08, 5'd1, 5'd2, 16'h0005); id_pc_plus4 = 32'h10;
        id_rs_data = 32'h55; id_rt_data = 32'h66;
        tick();
        tick();
        chk("rst.valid", {31'b0, ex_valid}, 0);
        chk("rst.func", {26'b0, ex_alu_func}, 0);
        chk("rst.a", ex_alu_a, 0);
        chk("rst.b", ex_alu_b, 0);
        chk("rst.dst", {27'b0, ex_dst_reg}, 0);
        chk("rst.ctl", {26'b0, ex_signed, ex_reg_write, ex_mem_read, ex_mem_write, ex_branch, ex_illegal}, 0);
        chk("rst.sd", ex_store_data, 0);
        reset = 1'b0; id_valid = 1'b0;
        tick();

        //          instr                              pc4      rs          rt          func   s  a          b            sd       dst rw mr mw br il
        v.push_back(mk(i_(6'h08, 1, 2, 16'hFFFF),      0,       5,          0,          6'h00, 1, 5,         32'hFFFFFFFF, 0,      2,  1, 0, 0, 0, 0));
        v.push_back(mk(r_(0, 3, 4, 4, 6'h03),          0,       0,          32'h80000000, 6'h23, 0, 4,       32'h80000000, 0,      4,  1, 0, 0, 0, 0));
        v.push_back(mk(i_(6'h0f, 0, 6, 16'h1234),      0,       0,          0,          6'h20, 0, 16,        32'h00001234, 0,      6,  1, 0, 0, 0, 0));
        v.push_back(mk(r_(1, 2, 7, 0, 6'h20),          0,       10,         3,          6'h00, 1, 10,        3,            0,      7,  1, 0, 0, 0, 0));
        v.push_back(mk(r_(1, 2, 8, 0, 6'h23),          0,       10,         3,          6'h01, 0, 10,        3,            0,      8,  1, 0, 0, 0, 0));
        v.push_back(mk(r_(1, 2, 9, 0, 6'h27),          0,       10,         3,          6'h11, 0, 10,        3,            0,      9,  1, 0, 0, 0, 0));
        v.push_back(mk(r_(1, 2, 10, 0, 6'h2a),         0,       10,         3,          6'h35, 1, 10,        3,            0,      10, 1, 0, 0, 0, 0));
        v.push_back(mk(r_(1, 2, 11, 0, 6'h06),         0,       3,          32'hF0,     6'h21, 0, 3,         32'hF0,       0,      11, 1, 0, 0, 0, 0));
        v.push_back(mk(i_(6'h0c, 1, 12, 16'h8000),     0,       5,          0,          6'h18, 0, 5,         32'h00008000, 0,      12, 1, 0, 0, 0, 0));
        v.push_back(mk(i_(6'h0a, 1, 13, 16'h8000),     0,       5,          0,          6'h35, 1, 5,         32'hFFFF8000, 0,      13, 1, 0, 0, 0, 0));
        v.push_back(mk(i_(6'h23, 1, 9, 16'hFFFC),      0,       100,        77,         6'h00, 0, 100,       32'hFFFFFFFC, 0,      9,  1, 1, 0, 0, 0));
        v.push_back(mk(i_(6'h2b, 1, 9, 16'h0004),      0,       100,        32'hDEAD,   6'h00, 0, 100,       4,            32'hDEAD, 0, 0, 0, 1, 0, 0));
        v.push_back(mk(i_(6'h04, 1, 2, 16'h0003),      0,       7,          9,          6'h33, 1, 7,         9,            0,      0,  0, 0, 0, 1, 0));
        v.push_back(mk(i_(6'h07, 1, 0, 16'h0003),      0,       7,          9,          6'h3f, 1, 7,         0,            0,      0,  0, 0, 0, 1, 0));
        v.push_back(mk(i_(6'h01, 1, 0, 16'h0003),      0,       7,          9,          6'h3b, 1, 7,         0,            0,      0,  0, 0, 0, 1, 0));
        v.push_back(mk({6'h03, 26'h10},                400,     0,          0,          6'h1a, 0, 400,       0,            0,      31, 1, 0, 0, 1, 0));
        v.push_back(mk(r_(1, 0, 5, 0, 6'h09),          800,     44,         0,          6'h1a, 0, 800,       0,            0,      5,  1, 0, 0, 1, 0));
        v.push_back(mk(r_(1, 0, 0, 0, 6'h08),          0,       0,          0,          6'h00, 0, 0,         0,            0,      0,  0, 0, 0, 1, 0));
        v.push_back(mk(i_(6'h3f, 0, 0, 16'h0000),      0,       0,          0,          6'h00, 0, 0,         0,            0,      0,  0, 0, 0, 0, 1));
        v.push_back(mk(r_(0, 0, 0, 0, 6'h3f),          0,       0,          0,          6'h00, 0, 0,         0,            0,      0,  0, 0, 0, 0, 1));
        v.push_back(mk(r_(1, 2, 0, 0, 6'h20),          0,       10,         3,          6'h00, 1, 10,        3,            0,      0,  0, 0, 0, 0, 0));
        v.push_back(mk(i_(6'h0d, 1, 14, 16'h8001),     0,       0,          0,          6'h1e, 0, 0,         32'h00008001, 0,      14, 1, 0, 0, 0, 0));
        v.push_back(mk({6'h02, 26'h20},                0,       0,          0,          6'h00, 0, 0,         0,            0,      0,  0, 0, 0, 1, 0));
        v.push_back(mk(i_(6'h01, 1, 1, 16'h0003),      0,       0,          0,          6'h00, 0, 0,         0,            0,      0,  0, 0, 0, 0, 1));

        ex_ready = 1'b1;
        foreach (v[i]) begin
            id_valid = 1'b1; id_instr = v[i].instr; id_pc_plus4 = v[i].pc4;
            id_rs_data = v[i].rs; id_rt_data = v[i].rt;
            tick();
            chk($sformatf("v%0d.valid", i), {31'b0, ex_valid}, 1);
            chk($sformatf("v%0d.func", i), {26'b0, ex_alu_func}, {26'b0, v[i].func});
            chk($sformatf("v%0d.a", i), ex_alu_a, v[i].a);
            chk($sformatf("v%0d.b", i), ex_alu_b, v[i].b);
            chk($sformatf("v%0d.sd", i), ex_store_data, v[i].sd);
            chk($sformatf("v%0d.dst", i), {27'b0, ex_dst_reg}, {27'b0, v[i].dst});
            chk($sformatf("v%0d.ctl{s,rw,mr,mw,br,ill}", i),
                {26'b0, ex_signed, ex_reg_write, ex_mem_read, ex_mem_write, ex_branch, ex_illegal},
                {26'b0, v[i].sgn, v[i].rw, v[i].mr, v[i].mw, v[i].br, v[i].ill});
        end

        // stall: bne held while EX refuses
        id_instr = i_(6'h05, 5'd1, 5'd2, 16'h0010); id_rs_data = 7; id_rt_data = 9;
        tick();
        chk("stall.issue_func", {26'b0, ex_alu_func}, 32'h31);
        ex_ready = 1'b0;
        id_instr = i_(6'h08, 5'd3, 5'd4, 16'h0001); id_rs_data = 32'hAAAA; id_rt_data = 32'hBBBB;
        for (int c = 0; c < 3; c++) begin
            tick();
            chk($sformatf("stall%0d.id_ready", c), {31'b0, id_ready}, 0);
            chk($sformatf("stall%0d.valid", c), {31'b0, ex_valid}, 1);
            chk($sformatf("stall%0d.func", c), {26'b0, ex_alu_func}, 32'h31);
            chk($sformatf("stall%0d.a", c), ex_alu_a, 7);
            chk($sformatf("stall%0d.b", c), ex_alu_b, 9);
            chk($sformatf("stall%0d.ctl", c), {27'b0, ex_signed, ex_reg_write, ex_branch, ex_mem_read, ex_mem_write}, 32'b10100);
        end
        ex_ready = 1'b1; id_valid = 1'b0;
        tick();
        chk("drain.valid", {31'b0, ex_valid}, 0);

        // flush drops the simultaneous transfer
        id_valid = 1'b1; flush = 1'b1;
        id_instr = i_(6'h08, 5'd1, 5'd5, 16'h0042); id_rs_data = 32'h1234;
        tick();
        flush = 1'b0; id_valid = 1'b0;
        chk("flush.valid", {31'b0, ex_valid}, 0);
        for (int c = 0; c < 3; c++) begin
            tick();
            chk($sformatf("flush%0d.valid", c), {31'b0, ex_valid}, 0);
        end

        // flush kills a live entry
        id_valid = 1'b1; id_instr = i_(6'h09, 5'd1, 5'd3, 16'h0001);
        tick();
        chk("live.valid", {31'b0, ex_valid}, 1);
        id_valid = 1'b0; ex_ready = 1'b0; flush = 1'b1;
        tick();
        flush = 1'b0;
        chk("live_flush.valid", {31'b0, ex_valid}, 0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
